cld_seq_ctrl: RTL and testbench
===============================

Name: cld_seq_ctrl

Overview:
- Sequencer that builds a WIDTH-bit adder out of one shared 4-bit carry-lookahead adder (cld).
- Accepts wide operands on a valid/ready handshake. Feeds one 4-bit slice per cycle, LSB slice first, and chains the carry through a register.
- Presents the registered sum and carry-out on a valid/ready result handshake.
- Sits between a host datapath and a single cld instance, so wide additions reuse the existing 4-bit adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived number of 4-bit slices; not overridden by users.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept operands; high only in IDLE.
- A  input  WIDTH  operand A, sampled on the in handshake.
- B  input  WIDTH  operand B, sampled on the in handshake.
- Cin  input  1  carry-in, sampled on the in handshake.
- out_valid  output  1  S/Cout hold a completed result; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- S  output  WIDTH  registered sum.
- Cout  output  1  registered final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, slice index=0, carry reg=0.
  - Operand regs=0, S=0, Cout=0.
  - out_valid=0, busy=0, in_ready=1 (decoded from state).
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = !IDLE.
- IDLE: on in_valid&&in_ready at an edge:
  - latch A, B into operand regs and Cin into the carry reg.
  - idx<=0, go RUN.
  - S and Cout keep their previous values until overwritten.
- RUN: cld driven combinationally:
  - cld.A = opA[4*idx+:4], cld.B = opB[4*idx+:4], cld.Cin = carry reg.
  - Each edge: S[4*idx+:4] <= cld.S, carry <= cld.Cout, idx <= idx+1.
  - When idx==NSLICE-1: Cout <= cld.Cout, idx <= 0, go DONE.
  - in_valid is ignored while in RUN.
- Latency: the accept edge is E0. Slice k is registered at edge E(k+1). out_valid rises after edge E(NSLICE), i.e. 4 cycles for WIDTH=16.
- DONE:
  - S and Cout are held stable while out_ready=0.
  - On out_valid&&out_ready: go IDLE, so in_ready=1 the next cycle.
  - No same-cycle accept of a new operand (no overlap).
- Width rule: {Cout,S} == A + B + Cin, mod 2^(WIDTH+1).
- Partial sum: S bits above the current slice may hold stale data during RUN. S is only meaningful while out_valid=1.
- Simultaneous events:
  - in_valid in RUN or DONE has no effect.
  - out_ready outside DONE has no effect.
- Reset mid-operation: the current operation is aborted immediately and all registers return to reset values. No out_valid is produced for the aborted request.
- cld select logic: when idx is outside 0..NSLICE-1, the cld inputs are driven to 0.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - SLICE_W=4.
- Sub-module: the existing 4-bit carry-lookahead adder cld (ports A, B, Cin, S, Cout), instantiated once.
- FSM, slice mux and registers stay in cld_seq_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> S=0x0000, Cout=0, out_valid=0, busy=0, in_ready=1. Release; the first edge accepts.
- Simple add: A=0x0001, B=0x0002, Cin=0 accepted at E0 -> out_valid=1 after E4 with S=0x0003, Cout=0; busy=1 during E1..E4.
- Full carry ripple: A=0xFFFF, B=0x0000, Cin=1 -> S=0x0000, Cout=1. A=0x9696, B=0x6969, Cin=0 -> S=0xFFFF, Cout=0.
- Backpressure: A=0x5A5A, B=0xA5A5, Cin=1 with out_ready=0 for 3 cycles after DONE -> S=0x0000, Cout=1 held stable, in_ready=0. A new in_valid with A=0x1111 is ignored. After the out_ready pulse, in_ready=1 the next cycle.
- Reset mid-RUN: A=0x0F0F, B=0x0101, Cin=0; pulse rst_n low after E2 -> S=0, out_valid never rises. A following A=0x0F0F, B=0x0101 -> S=0x1010, Cout=0.
- Back-to-back: two requests, A=0x8000/B=0x8000/Cin=0 then A=0x7FFF/B=0x0001/Cin=0, with out_ready=1 -> results S=0x0000/Cout=1 then S=0x8000/Cout=0. The second accept occurs exactly one cycle after the first result handshake.

Source files
------------

// File: rtl/cld_seq_ctrl_pkg.sv
// Shared types and constants for the slice-serial adder sequencer.
package cld_seq_ctrl_pkg;

   localparam int unsigned SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operand slice presented to the shared 4-bit adder
   typedef struct packed {
      logic [SLICE_W-1:0] a;
      logic [SLICE_W-1:0] b;
      logic               cin;
   } slice_in_t;

endpackage

// File: rtl/cld_seq_ctrl_cld.sv
// 4-bit carry-lookahead adder shared by the sequencer.
module cld_seq_ctrl_cld
   import cld_seq_ctrl_pkg::*;
(
   input  logic [SLICE_W-1:0] A,
   input  logic [SLICE_W-1:0] B,
   input  logic               Cin,
   output logic [SLICE_W-1:0] S,
   output logic               Cout
);

   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] g;
   logic [SLICE_W:0]   c;

   assign p = A ^ B;
   assign g = A & B;

   // All carries computed in parallel from generate/propagate terms
   assign c[0] = Cin;
   assign c[1] = g[0] | (p[0] & Cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & Cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & Cin);

   assign S    = p ^ c[SLICE_W-1:0];
   assign Cout = c[SLICE_W];

endmodule

// File: rtl/cld_seq_ctrl.sv
// Wide adder built by stepping one shared 4-bit CLA across the operands,
// LSB slice first, with the carry chained through a register.
module cld_seq_ctrl
   import cld_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             busy
);

   localparam int unsigned NSLICE = WIDTH / SLICE_W;
   localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_t             state_q;
   state_t             state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [WIDTH-1:0]   op_a_q;
   logic [WIDTH-1:0]   op_b_q;
   logic               carry_q;
   logic [WIDTH-1:0]   s_q;
   logic               cout_q;
   slice_in_t          slice;
   logic [SLICE_W-1:0] cld_s;
   logic               cld_cout;
   logic               last_slice;

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign S          = s_q;
   assign Cout       = cout_q;
   assign last_slice = (32'(idx_q) == NSLICE - 1);

   // Slice select; out-of-range index parks the adder inputs at zero
   always_comb begin
      slice = '0;
      if (32'(idx_q) < NSLICE) begin
         slice.a   = op_a_q[SLICE_W*32'(idx_q) +: SLICE_W];
         slice.b   = op_b_q[SLICE_W*32'(idx_q) +: SLICE_W];
         slice.cin = carry_q;
      end
   end

   cld_seq_ctrl_cld cld (
      .A    (slice.a),
      .B    (slice.b),
      .Cin  (slice.cin),
      .S    (cld_s),
      .Cout (cld_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)   state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    if (out_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture and per-slice accumulation of sum and carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_a_q  <= A;
                  op_b_q  <= B;
                  carry_q <= Cin;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               s_q[SLICE_W*32'(idx_q) +: SLICE_W] <= cld_s;
               carry_q <= cld_cout;
               if (last_slice) begin
                  cout_q <= cld_cout;
                  idx_q  <= '0;
               end else begin
                  idx_q  <= idx_q + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cld_seq_ctrl.sv
// Scoreboard bench for cld_seq_ctrl: stimulus pushes expected {Cout,S},
// a negedge monitor pops and compares on each result handshake.
module tb_cld_seq_ctrl;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] S;
   logic         Cout;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int hs_cyc = -1;
   int acc_cyc = 0;
   logic [W:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cld_seq_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result monitor
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: S=0x%0h Cout=%0b with nothing expected (t=%0t)",
                     S, Cout, $time);
         end else if (out_ready) begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk("sum", 32'(S), 32'(e[W-1:0]));
            chk("cout", 32'(Cout), 32'(e[W]));
            hs_cyc = cyc + 1;
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input bit push);
      logic [W:0] sum;
      int n;
      sum = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
      if (push) exp_q.push_back(sum);
      A = a; B = b; Cin = c; in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL valid_timeout: out_valid stayed 0 for %0d cycles", n);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      A = 16'h0001; B = 16'h0002; Cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s", 32'(S), 32'h0000);
      chk("rst_cout", 32'(Cout), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Simple add: held request accepted on the first edge after release
      exp_q.push_back(17'h0_0003);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("e0_busy", 32'(busy), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         chk("lat_busy", 32'(busy), 32'd1);
         chk("lat_out_valid", 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      chk("post_hs_in_ready", 32'(in_ready), 32'd1);

      // Carry ripple across all slices
      send(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      send(16'h9696, 16'h6969, 1'b0, 1'b1);
      drain();

      // Backpressure with an ignored request in DONE
      out_ready = 1'b0;
      send(16'h5A5A, 16'hA5A5, 1'b1, 1'b1);
      wait_valid();
      @(posedge clk); #1;
      A = 16'h1111; B = 16'h0000; Cin = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("bp_s", 32'(S), 32'h0000);
         chk("bp_cout", 32'(Cout), 32'd1);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);

      // Reset mid-RUN aborts without a result
      send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_s", 32'(S), 32'h0000);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_no_valid", 32'(out_valid), 32'd0);
      send(16'h0F0F, 16'h0101, 1'b0, 1'b1);
      drain();

      // Back-to-back with out_ready held high
      send(16'h8000, 16'h8000, 1'b0, 1'b1);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      chk("b2b_accept_cycle", 32'(acc_cyc), 32'(hs_cyc + 1));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
